incr_stream_checker: RTL and testbench
======================================

Name: incr_stream_checker

Overview:
- Synthesizable downstream consumer of a free-running counter stream, such as the 4-bit incrementing counter driven in the concurrent-assertion feature tests.
- Checks in RTL that each valid sample equals the previous valid sample plus STEP, modulo 2^WIDTH. This is the hardware equivalent of "disable iff (...) x == $past(x) + STEP".
- Reports per-sample failures, a saturating failure count and a capture of the first failure.
- Sits between the counter generator and the bench scoreboard, so the bench can cross-check SVA results against a non-SVA implementation.

Parameters:
- WIDTH, 4: bit width of the sample.
- STEP, 1: expected increment per valid sample; the sum wraps modulo 2^WIDTH.
- ERR_CNT_W, 8: width of the failure and pass counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sample_valid_i  in  1  sample_data_i is valid this cycle.
- sample_data_i  in  WIDTH  counter value under check.
- disable_i  in  1  disable-iff condition; aborts and disarms the checker.
- clear_i  in  1  synchronous clear of counters and first-fail capture.
- armed_o  out  1  a previous sample is held; the next valid sample will be checked.
- fail_o  out  1  one-cycle pulse, the cycle after a failing sample.
- pass_o  out  1  one-cycle pulse, the cycle after a passing sample.
- fail_count_o  out  ERR_CNT_W  saturating count of failures.
- pass_count_o  out  ERR_CNT_W  saturating count of passes.
- first_fail_valid_o  out  1  first-fail capture is populated.
- first_fail_exp_o  out  WIDTH  expected value at the first failure.
- first_fail_act_o  out  WIDTH  actual value at the first failure.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs are 0;
  - state is IDLE;
  - past register is 0.
- FSM with two states:
  - IDLE: no past value held. A valid, non-disabled sample loads the past register and moves to ARMED; no check is made and neither pass_o nor fail_o pulses.
  - ARMED: a valid, non-disabled sample is compared with exp = past + STEP, truncated to WIDTH bits.
    - Match: pass_o pulses next cycle and pass_count increments.
    - Mismatch: fail_o pulses next cycle and fail_count increments.
    - In both cases the past register loads the actual sample, so the checker resynchronises after a failure.
- Wrap-around: with WIDTH=4 and STEP=1, the sequence 15 then 0 passes.
- Invalid cycles: the past register and state are held. Gaps between samples are legal and do not fail.
- disable_i high:
  - next state is IDLE and the sample is discarded;
  - no pulse is produced, including the cycle after;
  - counters and first-fail capture are untouched.
- Simultaneous disable_i and sample_valid_i: disable wins.
- clear_i high:
  - fail_count, pass_count and first_fail_* are zeroed next cycle;
  - FSM and past register are unaffected.
- Simultaneous clear_i and a checked sample: clear wins for the counters and capture, so the sample is not counted or captured. The pass_o/fail_o pulse still fires.
- Counters saturate at 2^ERR_CNT_W-1 and never wrap.
- First-fail capture: loads exp and act on the first mismatch while first_fail_valid_o=0, then freezes until clear_i or reset.
- armed_o equals (state==ARMED), registered.
- Latency: every output updates one clock after the sample edge.
- Reset mid-stream: everything returns to reset values immediately; the first valid sample after reset only arms the checker.

Optional Feature:
- Macro: INCR_STREAM_CHECKER_SVA_EN.
- Defined: the module adds a concurrent assertion on the rising edge of clk, disabled by (!rst_n || disable_i || !armed_o). It requires that a valid sample equal the expected value, matching the RTL check. It also adds a cover property for the wrap case ((2^WIDTH-1) -> 0). The assertion reports via $error and does not end the simulation.
- Undefined: pure RTL, no SVA constructs; outputs are identical.

Decomposition:
- Package incr_check_pkg holds:
  - the state enum typedef (IDLE, ARMED);
  - a function next_expected(past, step, width-masked);
  - a localparam for the saturation max.
- One natural sub-module, sat_counter (parameter W; ports inc, clr, count), instantiated twice for the pass and fail counts.

Test Plan:
- Clean run: reset, then valid samples 0..15, 0, 1 (WIDTH=4). Required: first sample only arms; 17 pass_o pulses; fail_count_o=0; the 15->0 wrap passes.
- Injected error: samples 3, 4, 6, 7. Required:
  - fail_o pulses once, the cycle after 6;
  - first_fail_exp_o=5, first_fail_act_o=6;
  - 7 passes (resync);
  - fail_count_o=1, pass_count_o=2.
- Disable: samples 2, 3, then disable_i high with sample 9, then 10, 11. Required: 9 is discarded, 10 re-arms with no check, 11 passes; no fail_o.
- Gaps and simultaneous events: samples 5, then 3 invalid cycles, then 6; then clear_i in the same cycle as mismatching sample 0. Required:
  - 6 passes;
  - fail_o pulses for the 0 sample;
  - counters read 0 afterwards;
  - first_fail_valid_o=0.
- Saturation and reset: ERR_CNT_W=2 with 5 consecutive mismatches. Required: fail_count_o stays at 3. Then assert rst_n low mid-stream. Required: all outputs 0 immediately, and armed_o=0 until the next valid sample.

Source files
------------

// File: rtl/incr_stream_checker_pkg.sv
// ---------------------------------------------------------------------------
// incr_check_pkg
// Shared types and helpers for the incrementing-stream checker:
//   state_e        : checker FSM states (IDLE = no past value, ARMED = holding one)
//   next_expected  : (past + step) truncated to a run-time width
//   ERR_CNT_W_DEF  : default width of the pass/fail counters
//   SAT_MAX_DEF    : saturation value of a default-width counter
// ---------------------------------------------------------------------------
package incr_check_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Widest sample the helper arithmetic supports.
  localparam int unsigned EXP_W         = 32;
  localparam int unsigned ERR_CNT_W_DEF = 8;
  localparam int unsigned SAT_MAX_DEF   = (1 << ERR_CNT_W_DEF) - 1;

  // Expected next sample: the sum wraps modulo 2^width.
  function automatic logic [EXP_W-1:0] next_expected(
    input logic [EXP_W-1:0] past,
    input logic [EXP_W-1:0] step,
    input int unsigned      width
  );
    logic [EXP_W-1:0] mask;
    mask = (width >= EXP_W) ? '1 : ((EXP_W'(1) << width) - EXP_W'(1));
    return (past + step) & mask;
  endfunction

endpackage

// File: rtl/incr_stream_checker_if.sv
// ---------------------------------------------------------------------------
// incr_stream_checker_if
// Sample stream from the counter generator into the checker.
//   sample_valid : sample_data is valid this cycle
//   sample_data  : counter value under check (WIDTH bits)
// Modports: master (generator side), slave (checker side).
// ---------------------------------------------------------------------------
interface incr_stream_checker_if #(
  parameter int unsigned WIDTH = 4
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample_data;

  modport master (output sample_valid, output sample_data);
  modport slave  (input  sample_valid, input  sample_data);
endinterface

// File: rtl/incr_stream_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : add one this cycle (ignored once saturated)
//   clr        : synchronous clear; has priority over inc
//   count      : current count
// ---------------------------------------------------------------------------
module sat_counter
  import incr_check_pkg::*;
#(
  parameter int unsigned W = ERR_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/incr_stream_checker.sv
// ---------------------------------------------------------------------------
// incr_stream_checker
// Checks that each valid sample equals the previous valid sample plus STEP
// (mod 2^WIDTH), the RTL counterpart of
//   disable iff (...) x == $past(x) + STEP
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_if (slave)        : sample_valid / sample_data stream
//   disable_i           : aborts and disarms the checker; the sample is dropped
//   clear_i             : synchronous clear of counters and first-fail capture
//   armed_o             : a past sample is held; the next valid one is checked
//   pass_o / fail_o     : one-cycle pulse the cycle after a checked sample
//   pass_count_o        : saturating pass count
//   fail_count_o        : saturating fail count
//   first_fail_*_o      : expected/actual values of the first mismatch
// Optional build macro INCR_STREAM_CHECKER_SVA_EN adds a concurrent assertion
// mirroring the RTL check and a cover property for the wrap to zero.
// ---------------------------------------------------------------------------
module incr_stream_checker
  import incr_check_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned STEP      = 1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  incr_stream_checker_if.slave s_if,
  input  logic                 disable_i,
  input  logic                 clear_i,
  output logic                 armed_o,
  output logic                 fail_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] fail_count_o,
  output logic [ERR_CNT_W-1:0] pass_count_o,
  output logic                 first_fail_valid_o,
  output logic [WIDTH-1:0]     first_fail_exp_o,
  output logic [WIDTH-1:0]     first_fail_act_o
);

  logic             sample_valid_i;
  logic [WIDTH-1:0] sample_data_i;

  assign sample_valid_i = s_if.sample_valid;
  assign sample_data_i  = s_if.sample_data;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] past_q, past_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             ff_valid_q, ff_valid_d;
  logic [WIDTH-1:0] ff_exp_q, ff_exp_d;
  logic [WIDTH-1:0] ff_act_q, ff_act_d;

  logic [WIDTH-1:0] exp_val;
  logic             take;
  logic             check;
  logic             match;

  assign exp_val = WIDTH'(next_expected(EXP_W'(past_q), EXP_W'(STEP), WIDTH));

  // A sample is consumed only when valid and not disabled; it is checked
  // only if a past value is already held.
  assign take  = sample_valid_i && !disable_i;
  assign check = take && (state_q == ST_ARMED);
  assign match = (sample_data_i == exp_val);

  always_comb begin
    state_d    = state_q;
    past_d     = past_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    ff_valid_d = ff_valid_q;
    ff_exp_d   = ff_exp_q;
    ff_act_d   = ff_act_q;

    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (disable_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Past always follows the latest accepted sample, so the checker
    // resynchronises to the stream after a mismatch.
    if (take) begin
      past_d = sample_data_i;
    end

    if (check) begin
      pass_d = match;
      fail_d = !match;
    end

    // Clear beats a same-cycle mismatch: the capture stays empty.
    if (clear_i) begin
      ff_valid_d = 1'b0;
      ff_exp_d   = '0;
      ff_act_d   = '0;
    end else if (check && !match && !ff_valid_q) begin
      ff_valid_d = 1'b1;
      ff_exp_d   = exp_val;
      ff_act_d   = sample_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      past_q     <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      ff_valid_q <= 1'b0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else begin
      state_q    <= state_d;
      past_q     <= past_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_valid_q <= ff_valid_d;
      ff_exp_q   <= ff_exp_d;
      ff_act_q   <= ff_act_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (check && match),
    .clr   (clear_i),
    .count (pass_count_o)
  );

  sat_counter #(.W(ERR_CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (check && !match),
    .clr   (clear_i),
    .count (fail_count_o)
  );

  assign armed_o            = (state_q == ST_ARMED);
  assign pass_o             = pass_q;
  assign fail_o             = fail_q;
  assign first_fail_valid_o = ff_valid_q;
  assign first_fail_exp_o   = ff_exp_q;
  assign first_fail_act_o   = ff_act_q;

`ifdef INCR_STREAM_CHECKER_SVA_EN
  a_incr_step : assert property (
    @(posedge clk) disable iff (!rst_n || disable_i || !armed_o)
    sample_valid_i |-> (sample_data_i == exp_val)
  ) else $error("incr_stream_checker: sample %0d, expected %0d", sample_data_i, exp_val);

  c_wrap : cover property (
    @(posedge clk) disable iff (!rst_n || disable_i || !armed_o)
    sample_valid_i && (past_q == {WIDTH{1'b1}}) && (sample_data_i == '0)
  );
`else
`endif

endmodule

// File: tb/tb_incr_stream_checker.sv
module tb_incr_stream_checker;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned STEP  = 1;
  localparam int          MOD   = 1 << WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic disable_i = 1'b0;
  logic clear_i = 1'b0;

  always #5 clk = ~clk;

  incr_stream_checker_if #(.WIDTH(WIDTH)) s_if ();

  logic             armed, fail_p, pass_p, ffv;
  logic [7:0]       fcnt, pcnt;
  logic [WIDTH-1:0] ffe, ffa;

  logic             armed2, fail2, pass2, ffv2;
  logic [1:0]       fcnt2, pcnt2;
  logic [WIDTH-1:0] ffe2, ffa2;

  incr_stream_checker #(.WIDTH(WIDTH), .STEP(STEP), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(s_if), .disable_i(disable_i), .clear_i(clear_i),
    .armed_o(armed), .fail_o(fail_p), .pass_o(pass_p),
    .fail_count_o(fcnt), .pass_count_o(pcnt),
    .first_fail_valid_o(ffv), .first_fail_exp_o(ffe), .first_fail_act_o(ffa)
  );

  incr_stream_checker #(.WIDTH(WIDTH), .STEP(STEP), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_if(s_if), .disable_i(disable_i), .clear_i(clear_i),
    .armed_o(armed2), .fail_o(fail2), .pass_o(pass2),
    .fail_count_o(fcnt2), .pass_count_o(pcnt2),
    .first_fail_valid_o(ffv2), .first_fail_exp_o(ffe2), .first_fail_act_o(ffa2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act !== req) $display("FAIL %s actual=%0d required=%0d", name, act, req);
    else n_pass++;
  endtask

  // Reference model: "have a past value" + plain integer arithmetic.
  bit m_have;
  int m_past, m_pcnt, m_fcnt, m_ffe, m_ffa;
  bit m_ffv, m_pass, m_fail;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_have = 0; m_past = 0; m_pcnt = 0; m_fcnt = 0;
    m_ffv = 0; m_ffe = 0; m_ffa = 0; m_pass = 0; m_fail = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit dis, input bit clr);
    int e;
    m_pass = 0; m_fail = 0;
    if (dis) begin
      m_have = 0;
    end else if (v) begin
      if (m_have) begin
        e = (m_past + STEP) % MOD;
        if (d == e) begin
          m_pass = 1;
          if (!clr) m_pcnt = sat(m_pcnt + 1, 255);
        end else begin
          m_fail = 1;
          if (!clr) begin
            m_fcnt = sat(m_fcnt + 1, 255);
            if (!m_ffv) begin m_ffv = 1; m_ffe = e; m_ffa = d; end
          end
        end
      end
      m_past = d;
      m_have = 1;
    end
    if (clr) begin
      m_pcnt = 0; m_fcnt = 0; m_ffv = 0; m_ffe = 0; m_ffa = 0;
    end
  endtask

  task automatic check_model();
    chk("armed", armed, m_have);
    chk("pass_o", pass_p, m_pass);
    chk("fail_o", fail_p, m_fail);
    chk("pass_count", pcnt, m_pcnt);
    chk("fail_count", fcnt, m_fcnt);
    chk("ff_valid", ffv, m_ffv);
    chk("ff_exp", ffe, m_ffe);
    chk("ff_act", ffa, m_ffa);
    chk("pass_count_w2", pcnt2, sat(m_pcnt, 3));
    chk("fail_count_w2", fcnt2, sat(m_fcnt, 3));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at
  // the same offset after the next rising edge.
  task automatic cycle(input bit v, input int d, input bit dis, input bit clr);
    s_if.sample_valid = v;
    s_if.sample_data  = WIDTH'(d);
    disable_i = dis;
    clear_i   = clr;
    @(posedge clk);
    model_step(v, d, dis, clr);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    s_if.sample_valid = 1'b0;
    s_if.sample_data  = '0;
    disable_i = 1'b0;
    clear_i   = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int grp;
    bit v;
    int d;
    bit dis;
    bit clr;
    bit ep;
    bit ef;
    bit ea;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int pulses;
  int v_ok, d_gen, e_int;

  initial begin
    s_if.sample_valid = 1'b0;
    s_if.sample_data  = '0;

    vecs = '{
      // group 0: injected error 3,4,6,7
      '{0, 1, 3, 0, 0, 0, 0, 1},
      '{0, 1, 4, 0, 0, 1, 0, 1},
      '{0, 1, 6, 0, 0, 0, 1, 1},
      '{0, 1, 7, 0, 0, 1, 0, 1},
      // group 1: disable with 9, re-arm on 10
      '{1, 1, 2, 0, 0, 0, 0, 1},
      '{1, 1, 3, 0, 0, 1, 0, 1},
      '{1, 1, 9, 1, 0, 0, 0, 0},
      '{1, 1, 10, 0, 0, 0, 0, 1},
      '{1, 1, 11, 0, 0, 1, 0, 1},
      // group 2: gaps, then clear with mismatching 0
      '{2, 1, 5, 0, 0, 0, 0, 1},
      '{2, 0, 0, 0, 0, 0, 0, 1},
      '{2, 0, 0, 0, 0, 0, 0, 1},
      '{2, 0, 0, 0, 0, 0, 0, 1},
      '{2, 1, 6, 0, 0, 1, 0, 1},
      '{2, 1, 0, 0, 1, 0, 1, 1}
    };

    // Reset state
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_armed", armed, 0);
    chk("rst_pass_count", pcnt, 0);
    chk("rst_ff_valid", ffv, 0);
    do_reset();

    // Clean run 0..15,0,1
    pulses = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(1, i % MOD, 0, 0);
      if (pass_p) pulses++;
      if (i == 0) chk("clean_first_no_pulse", pass_p | fail_p, 0);
      if (i == 16) chk("clean_wrap_pass", pass_p, 1);
    end
    chk("clean_pulses", pulses, 17);
    chk("clean_fail_count", fcnt, 0);
    chk("clean_pass_count", pcnt, 17);

    // Table-driven groups
    for (int g = 0; g < 3; g++) begin
      do_reset();
      for (int i = 0; i < NV; i++) begin
        if (vecs[i].grp == g) begin
          cycle(vecs[i].v, vecs[i].d, vecs[i].dis, vecs[i].clr);
          chk($sformatf("vec%0d_pass", i), pass_p, vecs[i].ep);
          chk($sformatf("vec%0d_fail", i), fail_p, vecs[i].ef);
          chk($sformatf("vec%0d_armed", i), armed, vecs[i].ea);
        end
      end
      cycle(0, 0, 0, 0);
      case (g)
        0: begin
          chk("inj_ff_exp", ffe, 5);
          chk("inj_ff_act", ffa, 6);
          chk("inj_fail_count", fcnt, 1);
          chk("inj_pass_count", pcnt, 2);
        end
        1: begin
          chk("dis_fail_count", fcnt, 0);
          chk("dis_pass_count", pcnt, 2);
        end
        default: begin
          chk("clr_fail_count", fcnt, 0);
          chk("clr_pass_count", pcnt, 0);
          chk("clr_ff_valid", ffv, 0);
        end
      endcase
    end

    // Saturation: 0 arms, then five mismatches
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 5, 0, 0);
    chk("sat_fail_count_w2", fcnt2, 3);
    chk("sat_fail_count_w8", fcnt, 5);
    chk("sat_ff_act", ffa, 5);

    // Reset mid-stream, asserted between edges
    s_if.sample_valid = 1'b1;
    s_if.sample_data  = 4'd6;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_armed", armed, 0);
    chk("mid_rst_fail_count", fcnt, 0);
    chk("mid_rst_fail_count_w2", fcnt2, 0);
    chk("mid_rst_ff", {ffv, ffe, ffa}, 0);
    chk("mid_rst_pulses", {pass_p, fail_p}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("post_rst_armed_idle", armed, 0);
    cycle(1, 9, 0, 0);
    chk("post_rst_arms", armed, 1);
    chk("post_rst_no_pulse", pass_p | fail_p, 0);

    // Randomized stream against the model
    do_reset();
    d_gen = 0;
    for (int i = 0; i < 400; i++) begin
      v_ok = ($urandom_range(0, 9) < 7);
      if (v_ok) begin
        if ($urandom_range(0, 9) == 0) d_gen = $urandom_range(0, MOD - 1);
        else d_gen = (d_gen + STEP) % MOD;
      end
      e_int = ($urandom_range(0, 19) == 0);
      cycle(v_ok, d_gen, e_int, ($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=%0d", n_total, -1);
    $fatal(1, "timeout");
  end

endmodule
